pipe_addsub: RTL

PIPE_ADDSUB -- requirements
Module: pipe_addsub

---
 rtl/pipe_addsub.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
// Pipelined add / subtract / saturating-add / accumulate unit with valid-ready flow control.
// The result is computed on acceptance into stage 1; later stages only carry it toward the output.
module pipe_addsub #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             acc_clr,
  output logic [WIDTH:0]   out_sum,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [STAGES-1:0]          v_q, v_d;
  logic [STAGES-1:0]          ovf_q, ovf_d;
  logic [STAGES-1:0][WIDTH:0] sum_q, sum_d;
  logic [WIDTH:0]             acc_q, acc_d;

  logic [STAGES-1:0] adv;
  logic              accept;
  logic [WIDTH:0]    res_sum;
  logic              res_ovf;
  logic [WIDTH:0]    add_full;
  logic [WIDTH:0]    acc_base;
  logic [WIDTH+1:0]  acc_full;

  // A stage may advance when it, or any stage downstream of it, is empty, or the sink is ready.
  always_comb begin
    logic all_full;
    adv = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      all_full = 1'b1;
      for (int j = k; j < int'(STAGES); j++) begin
        all_full = all_full & v_q[j];
      end
      adv[k] = out_ready | ~all_full;
    end
  end

  assign in_ready = adv[0];
  assign accept   = in_valid & in_ready;

  always_comb begin
    res_sum  = '0;
    res_ovf  = 1'b0;
    add_full = {1'b0, in_a} + {1'b0, in_b};
    // Clear happens before the add when both coincide.
    acc_base = acc_clr ? '0 : acc_q;
    acc_full = {1'b0, acc_base} + {2'b00, in_a};
    unique case (in_mode)
      2'b00: begin
        res_sum = add_full;
        res_ovf = add_full[WIDTH];
      end
      2'b01: begin
        res_sum = {1'b0, in_a} - {1'b0, in_b};
        res_ovf = (in_a < in_b);
      end
      2'b10: begin
        res_ovf = add_full[WIDTH];
        res_sum = add_full[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : add_full;
      end
      default: begin
        res_sum = acc_full[WIDTH:0];
        res_ovf = acc_full[WIDTH+1];
      end
    endcase
  end

  always_comb begin
    acc_d = acc_q;
    if (accept && (in_mode == 2'b11)) begin
      acc_d = acc_full[WIDTH:0];
    end else if (acc_clr) begin
      acc_d = '0;
    end
  end

  always_comb begin
    v_d   = v_q;
    sum_d = sum_q;
    ovf_d = ovf_q;
    if (adv[0]) begin
      v_d[0] = in_valid;
      if (in_valid) begin
        sum_d[0] = res_sum;
        ovf_d[0] = res_ovf;
      end
    end
    for (int k = 1; k < int'(STAGES); k++) begin
      if (adv[k]) begin
        v_d[k]   = v_q[k-1];
        sum_d[k] = sum_q[k-1];
        ovf_d[k] = ovf_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      sum_q <= '0;
      ovf_q <= '0;
      acc_q <= '0;
    end else begin
      v_q   <= v_d;
      sum_q <= sum_d;
      ovf_q <= ovf_d;
      acc_q <= acc_d;
    end
  end

  assign out_sum   = sum_q[STAGES-1];
  assign out_ovf   = ovf_q[STAGES-1];
  assign out_valid = v_q[STAGES-1];

endmodule
